pipelined_carry_select_adder: RTL and testbench

PIPELINED_CARRY_SELECT_ADDER -- requirements
Module: pipelined_carry_select_adder

---
 rtl/pcsa_pkg.sv | 14 +
 rtl/pipelined_carry_select_adder_csa_block.sv | 35 +++
 rtl/pipelined_carry_select_adder.sv | 166 ++++++++++++++++
 tb/tb_pipelined_carry_select_adder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcsa_pkg.sv
// Shared sizing helpers for the pipelined carry-select adder.
package pcsa_pkg;

  // Number of carry-select blocks (one pipeline stage per block).
  function automatic int pcsa_nblk(input int width, input int size);
    return (width + size - 1) / size;
  endfunction

  // Width of the most significant block, which may be narrower than SIZE.
  function automatic int pcsa_last_size(input int width, input int size);
    return width - (pcsa_nblk(width, size) - 1) * size;
  endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_csa_block.sv
// One carry-select block: two ripple sums (carry-in 0 and 1) and a final
// select driven by the carry resolved in the previous stage.
module csa_block #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel_c,
  output logic [W-1:0] sum,
  output logic         c_out
);

  logic [W-1:0] sum0;
  logic [W-1:0] sum1;
  logic         rip0;
  logic         rip1;

  // Ripple both speculative sums bit by bit.
  always_comb begin
    sum0 = '0;
    sum1 = '0;
    rip0 = 1'b0;
    rip1 = 1'b1;
    for (int i = 0; i < W; i++) begin
      sum0[i] = a[i] ^ b[i] ^ rip0;
      rip0    = (a[i] & b[i]) | (rip0 & (a[i] ^ b[i]));
      sum1[i] = a[i] ^ b[i] ^ rip1;
      rip1    = (a[i] & b[i]) | (rip1 & (a[i] ^ b[i]));
    end
  end

  assign sum   = sel_c ? sum1 : sum0;
  assign c_out = sel_c ? rip1 : rip0;

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder: {cout, s} = a + b + cin, one block of SIZE
// bits resolved per stage, NBLK = ceil(WIDTH/SIZE) stages.
// Optional build macro PCSA_OVERFLOW_EN adds the registered two's-complement
// overflow output ovf, aligned with s.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The whole pipeline advances together (adv = !out_valid || out_ready);
// in_ready = adv, and while out_valid && !out_ready every stage holds, so
// s/cout/out_valid stay stable and no input is taken. flush clears all
// valid bits at the edge regardless of adv and drops any offered input.
module pipelined_carry_select_adder
  import pcsa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef PCSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = pcsa_nblk(WIDTH, SIZE);
  localparam int LAST = pcsa_last_size(WIDTH, SIZE);

  logic adv;
  logic load;

  // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1 regs.
  logic [WIDTH-1:0] src_a [NBLK];
  logic [WIDTH-1:0] src_b [NBLK];
  logic [WIDTH-1:0] src_s [NBLK];
  logic             src_c [NBLK];
  logic             src_v [NBLK];

  // Block results placed at their bit position, zero elsewhere.
  logic [WIDTH-1:0] blk_sum [NBLK];
  logic             blk_c   [NBLK];

  logic [WIDTH-1:0] sum_d [NBLK];
  logic [WIDTH-1:0] sum_q [NBLK];
  logic [WIDTH-1:0] a_d   [NBLK];
  logic [WIDTH-1:0] a_q   [NBLK];
  logic [WIDTH-1:0] b_d   [NBLK];
  logic [WIDTH-1:0] b_q   [NBLK];
  logic             c_d   [NBLK];
  logic             c_q   [NBLK];
  logic             v_d   [NBLK];
  logic             v_q   [NBLK];

  assign adv      = !v_q[NBLK-1] || out_ready;
  assign load     = adv && !flush;
  assign in_ready = adv;

  // Chain each stage's inputs to the previous stage's registers.
  always_comb begin
    src_a[0] = a;
    src_b[0] = b;
    src_s[0] = '0;
    src_c[0] = cin;
    src_v[0] = in_valid;
    for (int k = 1; k < NBLK; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = sum_q[k-1];
      src_c[k] = c_q[k-1];
      src_v[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * SIZE;
    localparam int BW = (k == NBLK - 1) ? LAST : SIZE;

    logic [BW-1:0] bsum;

    csa_block #(.W(BW)) u_blk (
      .a     (src_a[k][LO +: BW]),
      .b     (src_b[k][LO +: BW]),
      .sel_c (src_c[k]),
      .sum   (bsum),
      .c_out (blk_c[k])
    );

    assign blk_sum[k] = WIDTH'(bsum) << LO;
  end

  // Next-state for every stage. Bits at and above the current block are
  // still zero in src_s, so OR-ing in the block result is enough.
  always_comb begin
    for (int k = 0; k < NBLK; k++) begin
      sum_d[k] = src_s[k] | blk_sum[k];
      a_d[k]   = src_a[k];
      b_d[k]   = src_b[k];
      c_d[k]   = blk_c[k];
      if (flush)    v_d[k] = 1'b0;
      else if (adv) v_d[k] = src_v[k];
      else          v_d[k] = v_q[k];
    end
  end

  // Stage registers; data only moves on an advancing, non-flush edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NBLK; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        v_q[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NBLK; k++) begin
        v_q[k] <= v_d[k];
        if (load) begin
          sum_q[k] <= sum_d[k];
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          c_q[k]   <= c_d[k];
        end
      end
    end
  end

  // The last stage carries operand copies that nothing downstream reads.
  logic unused_tail;
  assign unused_tail = ^{a_q[NBLK-1], b_q[NBLK-1]};

  assign s         = sum_q[NBLK-1];
  assign cout      = c_q[NBLK-1];
  assign out_valid = v_q[NBLK-1];

`ifdef PCSA_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;
  logic carry_msb;

  // Carry into the MSB recovered from a ^ b ^ sum at that bit.
  always_comb begin
    carry_msb = src_a[NBLK-1][WIDTH-1] ^ src_b[NBLK-1][WIDTH-1]
              ^ blk_sum[NBLK-1][WIDTH-1];
    ovf_d     = carry_msb ^ blk_c[NBLK-1];
  end

  // Overflow register, moves in lockstep with the final sum stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf_q <= 1'b0;
    else if (load) ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Bench for pipelined_carry_select_adder at WIDTH=8, SIZE=3 (three stages).
// Optional build macro PCSA_OVERFLOW_EN also checks the ovf output.
module tb_pipelined_carry_select_adder;

  localparam int W    = 8;
  localparam int SZ   = 3;
  localparam int NBLK = 3;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
`ifdef PCSA_OVERFLOW_EN
  logic         ovf;
`endif

  int n_tests;
  int n_fail;
  int cyc;
  int res_cnt;
  logic stall_seen;

  // Expected {ovf, cout, s} and the cycle each op was accepted.
  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  pipelined_carry_select_adder #(.WIDTH(W), .SIZE(SZ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef PCSA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv);
    int unsigned u;
    int          sa;
    int          sb;
    int          sg;
    logic        o;
    logic [31:0] uv;
    u  = int'(av) + int'(bv) + int'(cv);
    sa = $signed(av);
    sb = $signed(bv);
    sg = sa + sb + int'(cv);
    o  = (sg > 127) || (sg < -128);
    uv = u;
    return {o, uv[W:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    int           c;
    if (rst_n) begin
      if (out_valid && exp_q.size() == 0)
        check("stale_valid", 32'(out_valid), 32'd0);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        c = acc_q.pop_front();
        res_cnt++;
        check("sum", 32'(s), 32'(e[W-1:0]));
        check("cout", 32'(cout), 32'(e[W]));
`ifdef PCSA_OVERFLOW_EN
        check("ovf", 32'(ovf), 32'(e[W+1]));
`endif
        if (!stall_seen) check("latency", 32'(cyc - c), 32'(NBLK));
      end
      if (out_valid && !out_ready) stall_seen = 1'b1;
      if (flush) begin
        exp_q.delete();
        acc_q.delete();
      end
      if (in_valid && in_ready && !flush) begin
        exp_q.push_back(model(a, b, cin));
        acc_q.push_back(cyc);
      end
      if (exp_q.size() == 0) stall_seen = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic fl, input logic ordy);
    @(posedge clk);
    #2;
    in_valid  = v;
    a         = av;
    b         = bv;
    cin       = cv;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drive_rand(input logic ordy);
    drive(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      idle();
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed + random sequences ----------------
  initial begin
    logic [W-1:0] held_s;
    logic         held_c;
    int           base;
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    res_cnt    = 0;
    stall_seen = 1'b0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    out_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_s", 32'(s), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    #1;
    rst_n = 1'b1;

    // Single op: FF + 01 -> 00 carry 1, valid exactly one cycle.
    drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("single_v0", 32'(out_valid), 32'd0);
    for (int j = 1; j <= 4; j++) begin
      idle();
      @(negedge clk);
      check("single_valid_pattern", 32'(out_valid), 32'(j == NBLK));
      if (j == NBLK) begin
        check("single_s", 32'(s), 32'h00);
        check("single_cout", 32'(cout), 32'd1);
      end
    end
    drain();

    // Streaming: 256 back-to-back random ops.
    base = res_cnt;
    for (int i = 0; i < 256; i++) begin
      drive_rand(1'b1);
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (i >= NBLK) check("stream_out_valid", 32'(out_valid), 32'd1);
    end
    for (int j = 0; j < NBLK; j++) begin
      idle();
      @(negedge clk);
      check("stream_tail_valid", 32'(out_valid), 32'd1);
    end
    drain();
    check("stream_count", 32'(res_cnt - base), 32'd256);

    // Backpressure: hold the output for 5 cycles.
    base = res_cnt;
    for (int i = 0; i < NBLK; i++) drive_rand(1'b1);
    drive_rand(1'b0);
    @(negedge clk);
    check("bp_valid_at_stall", 32'(out_valid), 32'd1);
    held_s = s;
    held_c = cout;
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b0);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_s_held", 32'(s), 32'(held_s));
      check("bp_cout_held", 32'(cout), 32'(held_c));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    drain();
    check("bp_count", 32'(res_cnt - base), 32'(NBLK));

    // Flush with three ops in flight (output stalled, flush overrides).
    base = res_cnt;
    for (int i = 0; i < NBLK; i++) drive_rand(1'b1);
    drive(1'b1, 8'h55, 8'h55, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    for (int j = 0; j < 3; j++) begin
      idle();
      @(negedge clk);
      check("flush_no_valid", 32'(out_valid), 32'd0);
    end
    check("flush_none_delivered", 32'(res_cnt - base), 32'd0);
    drive(1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
    for (int j = 1; j <= NBLK; j++) begin
      idle();
      @(negedge clk);
      if (j == NBLK) begin
        check("flush_next_valid", 32'(out_valid), 32'd1);
        check("flush_next_s", 32'(s), 32'h01);
        check("flush_next_cout", 32'(cout), 32'd1);
      end
    end
    drain();

    // Reset mid-stream with two ops in flight.
    drive(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_s", 32'(s), 32'd0);
    check("rst_mid_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      idle();
      @(negedge clk);
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end
    drive(1'b1, 8'h12, 8'h34, 1'b1, 1'b0, 1'b1);
    drain();

`ifdef PCSA_OVERFLOW_EN
    drive(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b1);
    drain();
`endif

    // Random mix of bubbles, backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
